// File: rtl/frog_score_bcd.sv
// Frogger BCD score counter with high-score register and
// active-low seven-segment display drivers.
module frog_score_bcd #(
    parameter int DIGITS = 3,
    parameter int ROW_W  = 16,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up,
    input  logic [ROW_W-1:0]      top_row,
    input  logic                  clear,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  rollover,
    output logic                  saturated
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic                up_q;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic [4*DIGITS-1:0] high_q, high_d;
    logic                roll_q, roll_d;
    logic [4*DIGITS-1:0] inc;
    logic                up_evt;
    logic                all_nines;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign up_evt    = up & ~up_q & (|top_row);
    assign all_nines = (score_q == ALL_NINES);

    // Ripple BCD increment: carry moves up only through nines.
    always_comb begin
        logic carry;
        inc   = score_q;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        score_d = score_q;
        roll_d  = 1'b0;
        if (clear) begin
            score_d = '0;
        end else if (up_evt) begin
            if (!all_nines) begin
                score_d = inc;
            end else if (WRAP) begin
                score_d = '0;
                roll_d  = 1'b1;
            end
        end
    end

    // Legal BCD packed MSD-high compares correctly as binary.
    assign high_d = (score_q > high_q) ? score_q : high_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            up_q    <= 1'b0;
            score_q <= '0;
            high_q  <= '0;
            roll_q  <= 1'b0;
        end else begin
            up_q    <= up;
            score_q <= score_d;
            high_q  <= high_d;
            roll_q  <= roll_d;
        end
    end

    always_comb begin
        logic [4*DIGITS-1:0] disp;
        logic                nz;
        logic [3:0]          d;
        disp    = show_high ? high_q : score_q;
        nz      = 1'b0;
        hex_out = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d  = disp[4*i +: 4];
            nz = nz | (d != 4'd0);
            if (i != 0 && !nz)
                hex_out[7*i +: 7] = 7'b1111111;
            else
                hex_out[7*i +: 7] = seg7(d);
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign rollover  = roll_q;
    assign saturated = !WRAP && all_nines;

endmodule

// File: tb/tb_frog_score_bcd.sv
// Bench for frog_score_bcd: three configurations driven in parallel
// and compared against an integer score model every cycle.
module tb_frog_score_bcd;

    logic        clk = 1'b0;
    logic        reset, up, clear, show_high;
    logic [15:0] top_row;

    logic [11:0] s0, h0, s1, h1;
    logic [20:0] x0, x1;
    logic [3:0]  s2, h2;
    logic [6:0]  x2;
    logic        ro0, sa0, ro1, sa1, ro2, sa2;

    int nvec = 0;
    int nbad = 0;

    int m_sc[3];
    int m_hi[3];
    bit m_ro[3];
    bit m_up;

    always #5 clk = ~clk;

    frog_score_bcd #(.DIGITS(3), .ROW_W(16), .WRAP(1'b1)) u0 (
        .clk(clk), .reset(reset), .up(up), .top_row(top_row),
        .clear(clear), .show_high(show_high),
        .score_bcd(s0), .high_bcd(h0), .hex_out(x0),
        .rollover(ro0), .saturated(sa0)
    );

    frog_score_bcd #(.DIGITS(3), .ROW_W(16), .WRAP(1'b0)) u1 (
        .clk(clk), .reset(reset), .up(up), .top_row(top_row),
        .clear(clear), .show_high(show_high),
        .score_bcd(s1), .high_bcd(h1), .hex_out(x1),
        .rollover(ro1), .saturated(sa1)
    );

    frog_score_bcd #(.DIGITS(1), .ROW_W(16), .WRAP(1'b1)) u2 (
        .clk(clk), .reset(reset), .up(up), .top_row(top_row),
        .clear(clear), .show_high(show_high),
        .score_bcd(s2), .high_bcd(h2), .hex_out(x2),
        .rollover(ro2), .saturated(sa2)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nd(input int k);
        return (k == 2) ? 1 : 3;
    endfunction

    function automatic bit wr(input int k);
        return k != 1;
    endfunction

    function automatic int pw10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] segtab(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    function automatic logic [63:0] bcd(input int v, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / pw10(i)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] hexv(input int v, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            if (i > 0 && v < pw10(i)) r[7*i +: 7] = 7'h7F;
            else r[7*i +: 7] = segtab((v / pw10(i)) % 10);
        end
        return r;
    endfunction

    task automatic model_step();
        bit ev;
        int mx;
        ev = up && !m_up && (top_row != 0);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_sc[k] = 0;
                m_hi[k] = 0;
                m_ro[k] = 0;
            end else begin
                mx = pw10(nd(k)) - 1;
                if (m_sc[k] > m_hi[k]) m_hi[k] = m_sc[k];
                m_ro[k] = 0;
                if (clear) m_sc[k] = 0;
                else if (ev) begin
                    if (m_sc[k] < mx) m_sc[k]++;
                    else if (wr(k)) begin
                        m_sc[k] = 0;
                        m_ro[k] = 1;
                    end
                end
            end
        end
        m_up = reset ? 1'b0 : up;
    endtask

    task automatic chk_inst(input int k, input logic [63:0] s,
                            input logic [63:0] h, input logic [63:0] x,
                            input logic r, input logic sat);
        int d, disp;
        d    = nd(k);
        disp = show_high ? m_hi[k] : m_sc[k];
        check($sformatf("score%0d", k), s, bcd(m_sc[k], d));
        check($sformatf("high%0d", k), h, bcd(m_hi[k], d));
        check($sformatf("hex%0d", k), x, hexv(disp, d));
        check($sformatf("roll%0d", k), 64'(r), 64'(m_ro[k]));
        check($sformatf("sat%0d", k), 64'(sat),
              64'(!wr(k) && m_sc[k] == pw10(d) - 1));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk_inst(0, 64'(s0), 64'(h0), 64'(x0), ro0, sa0);
        chk_inst(1, 64'(s1), 64'(h1), 64'(x1), ro1, sa1);
        chk_inst(2, 64'(s2), 64'(h2), 64'(x2), ro2, sa2);
    endtask

    task automatic press(input int n);
        for (int i = 0; i < n; i++) begin
            up = 1'b1;
            step();
            up = 1'b0;
            step();
        end
    endtask

    initial begin
        m_up = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_sc[k] = 0;
            m_hi[k] = 0;
            m_ro[k] = 0;
        end
        reset = 1'b1; up = 1'b0; clear = 1'b0;
        show_high = 1'b0; top_row = '0;
        step();
        step();
        check("rst_hex", 64'(x0), 64'({7'h7F, 7'h7F, 7'h40}));
        check("rst_score", 64'(s0), 64'(12'h000));

        reset = 1'b0;
        top_row = 16'h0010;
        press(12);
        check("plan12", 64'(s0), 64'(12'h012));
        check("plan12_hex", 64'(x0), 64'({7'h7F, 7'h79, 7'h24}));

        up = 1'b1;
        repeat (10) step();
        up = 1'b0;
        step();
        check("held", 64'(s0), 64'(12'h013));

        top_row = '0;
        press(1);
        check("norow", 64'(s0), 64'(12'h013));
        up = 1'b1;
        step();
        top_row = 16'h8000;
        step();
        up = 1'b0;
        step();
        check("late_row", 64'(s0), 64'(12'h013));

        clear = 1'b1;
        step();
        clear = 1'b0;
        press(999);
        check("pre999", 64'(s0), 64'(12'h999));
        up = 1'b1;
        step();
        check("wrap_s", 64'(s0), 64'(12'h000));
        check("wrap_ro", 64'(ro0), 64'(1'b1));
        check("wrap_hi", 64'(h0), 64'(12'h999));
        check("sat_s", 64'(s1), 64'(12'h999));
        check("sat_lv", 64'(sa1), 64'(1'b1));
        up = 1'b0;
        step();
        check("ro_1cyc", 64'(ro0), 64'(1'b0));

        reset = 1'b1;
        step();
        reset = 1'b0;
        press(57);
        clear = 1'b1;
        up = 1'b1;
        step();
        clear = 1'b0;
        up = 1'b0;
        step();
        check("clr_s", 64'(s0), 64'(12'h000));
        check("clr_hi", 64'(h0), 64'(12'h057));
        show_high = 1'b1;
        #1;
        check("show_hi", 64'(x0), 64'({7'h7F, 7'h12, 7'h78}));
        step();
        show_high = 1'b0;

        reset = 1'b1;
        step();
        reset = 1'b0;
        press(25);
        reset = 1'b1;
        up = 1'b1;
        step();
        check("midrst_s", 64'(s0), 64'(12'h000));
        check("midrst_hex", 64'(x0), 64'({7'h7F, 7'h7F, 7'h40}));
        reset = 1'b0;
        step();
        check("held_rst", 64'(s0), 64'(12'h001));
        up = 1'b0;
        step();

        for (int i = 0; i < 1500; i++) begin
            up        = 1'($urandom % 2);
            top_row   = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
            clear     = ($urandom % 50 == 0);
            reset     = ($urandom % 300 == 0);
            show_high = 1'($urandom % 2);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
